// File: rtl/adc_bus_responder_pkg.sv
// Shared types and constants for the ADC0804-style bus responder.
package adc_bus_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam logic        INACTIVE   = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_HOLD = 3'd1,
      CONVERT = 3'd2,
      DONE    = 3'd3,
      READ    = 3'd4
   } state_t;

endpackage

// File: rtl/adc_bus_responder_strobe_sync.sv
// Multi-stage synchronizer for one asynchronous active-low strobe; resets to the inactive level.
module strobe_sync
   import adc_bus_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {STAGES{INACTIVE}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/adc_bus_responder.sv
// Stand-in for an ADC0804 converter: timed conversion on each write strobe,
// completion on intr_n, result offered on dout while a read strobe is active.
module adc_bus_responder
   import adc_bus_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned CONV_CYCLES = 64,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              wr_n,
   input  logic              rd_n,
   input  logic [DATA_W-1:0] sample_in,
   output logic              intr_n,
   output logic [DATA_W-1:0] dout,
   output logic              dout_oe,
   output logic              conv_busy,
   output logic              proto_err
);

   localparam int unsigned     CNT_W    = $clog2(CONV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

   logic              w_cs_s;
   logic              w_wr_s;
   logic              w_rd_s;
   logic              w_wr_act;
   logic              w_rd_act;
   logic              w_rd_rise;
   logic              w_cnt_last;
   logic              w_proto;
   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_result;
   logic              r_intr_n;
   logic              r_proto_err;
   logic              r_rd_act_d;

   strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (cs_n),
      .o_sync  (w_cs_s)
   );

   strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (wr_n),
      .o_sync  (w_wr_s)
   );

   strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (rd_n),
      .o_sync  (w_rd_s)
   );

   assign w_wr_act   = !w_cs_s && !w_wr_s;
   assign w_rd_act   = !w_cs_s && !w_rd_s;
   // A read held across several cycles of WR_HOLD/CONVERT is one violation, flagged at its start.
   assign w_rd_rise  = w_rd_act && !r_rd_act_d;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_wr_act) begin
               w_next = WR_HOLD;
            end else if (w_rd_act) begin
               w_next = READ;
            end
         end
         WR_HOLD: begin
            if (!w_wr_act) begin
               w_next = CONVERT;
            end
         end
         CONVERT: begin
            if (w_wr_act) begin
               w_next = WR_HOLD;
            end else if (w_cnt_last) begin
               w_next = DONE;
            end
         end
         READ: begin
            if (w_wr_act) begin
               w_next = WR_HOLD;
            end else if (!w_rd_act) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_proto = 1'b0;
      case (r_state)
         IDLE, DONE:       w_proto = w_wr_act && w_rd_act;
         WR_HOLD, CONVERT: w_proto = w_rd_rise;
         READ:             w_proto = w_wr_act;
         default:          w_proto = 1'b0;
      endcase
   end

   always_comb begin
      dout_oe   = (r_state == READ);
      conv_busy = (r_state == CONVERT);
      dout      = r_result;
      intr_n    = r_intr_n;
      proto_err = r_proto_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_result    <= '0;
         r_intr_n    <= 1'b1;
         r_proto_err <= 1'b0;
         r_rd_act_d  <= 1'b0;
      end else begin
         r_proto_err <= w_proto;
         r_rd_act_d  <= w_rd_act;
         case (r_state)
            WR_HOLD: begin
               if (!w_wr_act) begin
                  r_cnt    <= '0;
                  r_intr_n <= 1'b1;
               end
            end
            CONVERT: begin
               // An abort on the final cycle wins: the result register is left untouched.
               if (!w_wr_act) begin
                  if (w_cnt_last) begin
                     r_result <= sample_in;
                     r_intr_n <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            IDLE, DONE: begin
               if (!w_wr_act && w_rd_act) begin
                  r_intr_n <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_bus_responder.sv
// Bench for adc_bus_responder: directed handshake scenarios plus random strobe traffic,
// all checked every cycle against a transaction-level model of the converter.
module tb_adc_bus_responder;

   localparam int unsigned DW   = 8;
   localparam int unsigned CONV = 64;
   localparam int unsigned NS   = 2;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          cs_n      = 1'b1;
   logic          wr_n      = 1'b1;
   logic          rd_n      = 1'b1;
   logic [DW-1:0] sample_in = '0;
   logic          intr_n;
   logic [DW-1:0] dout;
   logic          dout_oe;
   logic          conv_busy;
   logic          proto_err;

   int          errors   = 0;
   int          checks   = 0;
   int unsigned cyc      = 0;
   int          perr_cnt = 0;
   int          oe_cnt   = 0;

   // Model: input history for the synchronizer delay plus converter status flags.
   bit            h_cs [NS];
   bit            h_wr [NS];
   bit            h_rd [NS];
   bit            m_hold;
   bit            m_read;
   bit            m_ready;
   bit            m_prev_rd;
   bit            m_err;
   int            m_left;
   logic [DW-1:0] m_result;

   adc_bus_responder #(
      .DATA_W      (DW),
      .CONV_CYCLES (CONV),
      .SYNC_STAGES (NS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cs_n      (cs_n),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .sample_in (sample_in),
      .intr_n    (intr_n),
      .dout      (dout),
      .dout_oe   (dout_oe),
      .conv_busy (conv_busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NS); i++) begin
         h_cs[i] = 1'b1;
         h_wr[i] = 1'b1;
         h_rd[i] = 1'b1;
      end
      m_hold    = 1'b0;
      m_read    = 1'b0;
      m_ready   = 1'b0;
      m_prev_rd = 1'b0;
      m_err     = 1'b0;
      m_left    = 0;
      m_result  = '0;
   endtask

   task automatic model_step();
      bit c, w, r, wa, ra, rise;
      c = h_cs[NS-1];
      w = h_wr[NS-1];
      r = h_rd[NS-1];
      for (int i = int'(NS) - 1; i > 0; i--) begin
         h_cs[i] = h_cs[i-1];
         h_wr[i] = h_wr[i-1];
         h_rd[i] = h_rd[i-1];
      end
      h_cs[0] = cs_n;
      h_wr[0] = wr_n;
      h_rd[0] = rd_n;
      wa   = !c && !w;
      ra   = !c && !r;
      rise = ra && !m_prev_rd;
      m_err = 1'b0;
      if (m_hold) begin
         m_err = rise;
         if (!wa) begin
            m_hold  = 1'b0;
            m_left  = int'(CONV);
            m_ready = 1'b0;
         end
      end else if (m_left > 0) begin
         m_err = rise;
         if (wa) begin
            m_hold = 1'b1;
            m_left = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_result = sample_in;
               m_ready  = 1'b1;
            end
         end
      end else if (m_read) begin
         if (wa) begin
            m_err  = 1'b1;
            m_read = 1'b0;
            m_hold = 1'b1;
         end else if (!ra) begin
            m_read = 1'b0;
         end
      end else begin
         if (wa) begin
            m_hold = 1'b1;
            m_err  = ra;
         end else if (ra) begin
            m_read  = 1'b1;
            m_ready = 1'b0;
         end
      end
      m_prev_rd = ra;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("intr_n",    intr_n,    !m_ready);
         check("dout_oe",   dout_oe,   m_read);
         check("conv_busy", conv_busy, m_left > 0);
         check("proto_err", proto_err, m_err);
         check("dout",      dout,      m_result);
         if (proto_err) perr_cnt++;
         if (dout_oe)   oe_cnt++;
      end
   end

   function automatic logic sig(input int sel);
      case (sel)
         0:       return conv_busy;
         1:       return intr_n;
         default: return dout_oe;
      endcase
   endfunction

   // Returns the cycle number of the first edge after which the signal shows lvl, or -1.
   task automatic wait_for(input int sel, input logic lvl, input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         #1;
         if (sig(sel) === lvl) begin
            at = int'(cyc);
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_sel%0d: level %0b not seen within %0d cycles", sel, lvl, max);
      end
   endtask

   task automatic drive(input logic c, input logic w, input logic r);
      @(posedge clk);
      #2;
      cs_n = c;
      wr_n = w;
      rd_n = r;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic full_cycle(input logic [DW-1:0] s, output logic [DW-1:0] v);
      int t;
      sample_in = s;
      drive(1'b0, 1'b0, 1'b1);
      hold(4);
      drive(1'b1, 1'b1, 1'b1);
      wait_for(0, 1'b1, 20, t);
      wait_for(1, 1'b0, CONV + 10, t);
      drive(1'b0, 1'b1, 1'b0);
      wait_for(2, 1'b1, 20, t);
      v = dout;
      hold(2);
      drive(1'b1, 1'b1, 1'b1);
      wait_for(2, 1'b0, 20, t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int            t0, t, p0, o0;
      logic [DW-1:0] v;
      logic [DW-1:0] data_reg;

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_intr_n",    intr_n,    1'b1);
      check("rst_dout",      dout,      8'h00);
      check("rst_dout_oe",   dout_oe,   1'b0);
      check("rst_conv_busy", conv_busy, 1'b0);
      check("rst_proto_err", proto_err, 1'b0);
      #1 rst = 1'b0;
      hold(3);

      // Normal conversion and read-back
      sample_in = 8'hA5;
      drive(1'b0, 1'b0, 1'b1);
      hold(10);
      drive(1'b1, 1'b1, 1'b1);
      t0 = int'(cyc);
      wait_for(0, 1'b1, 20, t);
      check("wr_release_to_busy", t - t0, NS + 1);
      t0 = t;
      wait_for(1, 1'b0, CONV + 10, t);
      check("busy_to_intr", t - t0, CONV);
      drive(1'b0, 1'b1, 1'b0);
      t0 = int'(cyc);
      wait_for(2, 1'b1, 20, t);
      check("rd_to_oe", t - t0, NS + 1);
      check("rd_dout", dout, 8'hA5);
      check("rd_intr_cleared", intr_n, 1'b1);
      hold(4);
      drive(1'b1, 1'b1, 1'b1);
      t0 = int'(cyc);
      wait_for(2, 1'b0, 20, t);
      check("rd_release_to_oe_low", t - t0, NS + 1);

      // Second write 20 clk into CONVERT restarts the conversion
      sample_in = 8'h77;
      drive(1'b0, 1'b0, 1'b1);
      hold(3);
      drive(1'b1, 1'b1, 1'b1);
      wait_for(0, 1'b1, 20, t);
      hold(18);
      drive(1'b0, 1'b0, 1'b1);
      hold(5);
      check("abort_keeps_result", dout, 8'hA5);
      check("abort_not_busy", conv_busy, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      t0 = int'(cyc);
      wait_for(0, 1'b1, 20, t);
      hold(30);
      sample_in = 8'h3C;
      wait_for(1, 1'b0, CONV + 10, t);
      check("restart_latency", t - t0, NS + 1 + CONV);
      check("restart_result", dout, 8'h3C);

      // Read strobe during CONVERT (starting from DONE, intr_n is low until the write releases)
      sample_in = 8'h5A;
      drive(1'b0, 1'b0, 1'b1);
      hold(3);
      drive(1'b1, 1'b1, 1'b1);
      t0 = int'(cyc);
      wait_for(0, 1'b1, 20, t);
      hold(10);
      p0 = perr_cnt;
      o0 = oe_cnt;
      drive(1'b0, 1'b1, 1'b0);
      hold(5);
      drive(1'b1, 1'b1, 1'b1);
      wait_for(1, 1'b0, CONV + 10, t);
      check("early_rd_latency", t - t0, NS + 1 + CONV);
      check("early_rd_perr_pulses", perr_cnt - p0, 1);
      check("early_rd_no_drive", oe_cnt - o0, 0);
      check("early_rd_result", dout, 8'h5A);

      // Write and read together while in DONE
      p0 = perr_cnt;
      o0 = oe_cnt;
      drive(1'b0, 1'b0, 1'b0);
      hold(6);
      check("simul_intr_held", intr_n, 1'b0);
      check("simul_not_busy", conv_busy, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      t0 = int'(cyc);
      wait_for(1, 1'b1, 20, t);
      check("simul_intr_release", t - t0, NS + 1);
      check("simul_busy_at_release", conv_busy, 1'b1);
      check("simul_perr_pulses", perr_cnt - p0, 1);
      check("simul_no_drive", oe_cnt - o0, 0);
      wait_for(1, 1'b0, CONV + 10, t);

      // Asynchronous reset with the counter at 30
      sample_in = 8'h99;
      drive(1'b0, 1'b0, 1'b1);
      hold(2);
      drive(1'b1, 1'b1, 1'b1);
      wait_for(0, 1'b1, 20, t);
      hold(30);
      check("pre_reset_busy", conv_busy, 1'b1);
      check("pre_reset_dout", dout, 8'h5A);
      #2 rst = 1'b1;
      #1;
      check("async_rst_intr_n",    intr_n,    1'b1);
      check("async_rst_dout",      dout,      8'h00);
      check("async_rst_dout_oe",   dout_oe,   1'b0);
      check("async_rst_conv_busy", conv_busy, 1'b0);
      check("async_rst_proto_err", proto_err, 1'b0);
      hold(2);
      rst = 1'b0;
      hold(2);
      full_cycle(8'h00, v);
      check("post_rst_sample_00", v, 8'h00);
      full_cycle(8'hFF, v);
      check("post_rst_sample_ff", v, 8'hFF);

      // Controller-style loop with slow strobes: idle -> start -> start_wait -> convert/read
      sample_in = 8'h64;
      hold(8);
      drive(1'b0, 1'b0, 1'b1);
      hold(8);
      drive(1'b1, 1'b1, 1'b1);
      hold(8);
      wait_for(1, 1'b0, CONV + 40, t);
      drive(1'b0, 1'b1, 1'b0);
      hold(8);
      check("ctrl_oe_at_capture", dout_oe, 1'b1);
      data_reg = dout;
      drive(1'b1, 1'b1, 1'b1);
      hold(8);
      check("ctrl_data_reg", data_reg, 8'h64);

      // Random strobe traffic, checked cycle by cycle against the model
      for (int k = 0; k < 250; k++) begin
         int op, len;
         op  = int'($urandom_range(0, 7));
         len = int'($urandom_range(1, 12));
         sample_in = DW'($urandom);
         case (op)
            0, 1:    drive(1'b0, 1'b0, 1'b1);
            2, 3:    drive(1'b0, 1'b1, 1'b0);
            4:       drive(1'b0, 1'b0, 1'b0);
            5:       drive(1'b0, 1'b1, 1'b1);
            6:       drive(1'b1, 1'b0, 1'b0);
            default: len = int'($urandom_range(1, 90));
         endcase
         hold(len);
         if ($urandom_range(0, 2) != 0) drive(1'b1, 1'b1, 1'b1);
      end
      drive(1'b1, 1'b1, 1'b1);
      hold(CONV + 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
